// File: rtl/switch_pkg.sv
// Shared types and helpers for the 4-port switch datapath.
package switch_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [1:0]           port_idx_t;

  // Index of the set bit of a one-hot mask; the highest set bit wins if several are set.
  function automatic port_idx_t onehot_to_idx(input port_mask_t m);
    port_idx_t idx;
    idx = '0;
    for (int unsigned b = 0; b < NUM_PORTS; b++) begin
      if (m[b]) idx = port_idx_t'(b);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_out_scheduler_rr_arb4.sv
// Four-request round-robin arbiter; the pointer advances past the winner on every grant.
module rr_arb4
  import switch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  port_mask_t req_i,
  input  logic       en_i,
  output port_mask_t gnt_o
);

  port_idx_t rr_q, rr_d;
  port_idx_t idx;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    if (en_i) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = rr_q + port_idx_t'(k);
        if (req_i[idx] && (gnt_o == '0)) gnt_o[idx] = 1'b1;
      end
    end
    rr_d = rr_q;
    if (gnt_o != '0) rr_d = onehot_to_idx(gnt_o) + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/switch_out_scheduler.sv
// Per-output round-robin scheduler with multicast tracking; pops a head once every
// remaining destination is served in the current cycle.
module switch_out_scheduler
  import switch_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic       [NUM_PORTS-1:0]   head_valid_i,
  input  port_mask_t [NUM_PORTS-1:0]   head_target_i,
  input  logic       [NUM_PORTS-1:0]   out_ready_i,
  input  logic       [NUM_PORTS-1:0]   port_en_i,
  output port_mask_t [NUM_PORTS-1:0]   grant_o,
  output logic       [NUM_PORTS-1:0]   pop_o,
  output logic       [NUM_PORTS-1:0]   drop_o
);

  port_mask_t [NUM_PORTS-1:0] served_q, served_d;
  port_mask_t [NUM_PORTS-1:0] pend;
  port_mask_t [NUM_PORTS-1:0] req_out;
  port_mask_t [NUM_PORTS-1:0] gnt_out;
  port_mask_t [NUM_PORTS-1:0] gnt_in;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pend[i] = '0;
      if (head_valid_i[i])
        pend[i] = head_target_i[i] & ~served_q[i] & port_en_i & ~(port_mask_t'(1) << i);
    end
  end

  // Requests are indexed per output, grants per input: the two transposes below.
  always_comb begin
    for (int unsigned j = 0; j < NUM_PORTS; j++)
      for (int unsigned i = 0; i < NUM_PORTS; i++)
        req_out[j][i] = pend[i][j];
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_arb4 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_out[j]),
      .en_i  (out_ready_i[j] & ~rst),
      .gnt_o (gnt_out[j])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      for (int unsigned j = 0; j < NUM_PORTS; j++)
        gnt_in[i][j] = gnt_out[j][i];
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pop_o[i]    = ~rst & head_valid_i[i] & ((pend[i] & ~gnt_in[i]) == '0);
      drop_o[i]   = pop_o[i] & (pend[i] == '0) & (served_q[i] == '0);
      served_d[i] = served_q[i] | gnt_in[i];
      if (!head_valid_i[i] || pop_o[i]) served_d[i] = '0;
    end
  end

  assign grant_o = gnt_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) served_q <= '0;
    else     served_q <= served_d;
  end

endmodule

// File: doc/switch_out_scheduler.md
# switch_out_scheduler

Output scheduler for the 4-port switch. It sits between the per-input packet queues and the 4x4 crossbar. Each cycle it picks at most one input for every output port using per-output round-robin, and it tracks partially delivered multicast/broadcast heads. It pops an input queue only after every requested destination of its head packet has been served.

## Interface
- NUM_PORTS, 4, number of switch ports; fixed at 4 (one-hot `port_mask_t` masks).
- clk  in  1  switch clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- head_valid_i  in  4  bit i: input queue i non-empty; head fields valid.
- head_target_i  in  4x4  [i]: one-hot/multi-hot target mask of input i head packet (bit j = output j).
- out_ready_i  in  4  bit j: output j can accept a packet this cycle.
- port_en_i  in  4  bit j: output j enabled; disabled outputs are never granted.
- grant_o  out  4x4  [j]: one-hot input index selected for output j; all-zero = idle; drives crossbar select and output valid.
- pop_o  out  4  bit i: head of input i fully delivered (or dropped); queue pops at this clock edge.
- drop_o  out  4  bit i: head of input i popped with zero deliveries (empty effective mask); 1-cycle pulse.

## Operation
- State: served_q[i] (4 bits per input, destinations already delivered for current head); rr_q[j] (2-bit round-robin pointer per output).
- Effective pending mask per input: pend[i] = head_target_i[i] & ~served_q[i] & port_en_i & ~(1<<i). The self bit is always ignored (no hairpin). Pending is zero when head_valid_i[i]=0.
- Per output j:
  - Candidates are inputs with pend[i][j]=1, and only when out_ready_i[j]=1.
  - Priority order is rr_q[j], rr_q[j]+1, ... mod 4; the first candidate wins.
  - On a grant to input i, rr_q[j] <= (i+1) mod 4. With no grant, rr_q[j] holds.
- Per input i, with gnt[i] = set of outputs granted to i this cycle:
  - If head_valid_i[i] and (pend[i] & ~gnt[i]) == 0: pop_o[i]=1 and served_q[i] <= 0.
  - Otherwise: served_q[i] <= served_q[i] | gnt[i].
  - drop_o[i] = pop_o[i] & (pend[i]==0) & (served_q[i]==0). This covers a target mask of 0, self-only, or all-disabled outputs.
- If head_valid_i[i]=0, served_q[i] <= 0.
- An input may be granted several outputs in one cycle (parallel multicast).
- A blocked destination holds the head; the other outputs keep serving other inputs.
- Disabling an output mid-packet removes that bit from pending; the head may then pop without that delivery.
- grant_o, pop_o and drop_o are combinational from inputs and registered state. There are no combinational paths between grant_o and out_ready_i other than the gating defined above.

## Timing
- Reset (rst=1, asynchronous): served_q=0; rr_q[j]=0 (input 0 highest priority); grant_o, pop_o, drop_o forced 0 while rst is high.
- Latency:
  - Grant and pop are zero-cycle: a head presented in cycle t is granted in cycle t when the output is ready.
  - The queue presents its next head in t+1.
  - An N-destination multicast with all outputs ready completes in 1 cycle. Under contention it takes at most 3 extra cycles per output (round-robin fairness bound).
- Simultaneous events:
  - Pop and a new head on the same edge: served_q clears, so the new head starts fresh.
  - Several outputs updating rr_q in the same cycle is allowed; each rr_q[j] is independent.
- Reset mid-multicast discards served_q. After release the head is re-delivered to all targets; duplicates are accepted behaviour.
- Deassertion of rst is synchronised externally; the first grant occurs on the first cycle with rst=0.

## Structure
- Package switch_pkg holds:
  - NUM_PORTS=4
  - port_mask_t (logic [3:0])
  - port_idx_t (logic [1:0])
  - function onehot_to_idx
- Sub-module rr_arb4: one 4-request round-robin arbiter with its own rr_q pointer, enable/update on grant. It is instantiated 4x (one per output).
- The top level holds served_q, the pending/pop logic, and grant transposition.

## Test plan
- After reset, P0 head 4'b0010, all ready and enabled → grant_o[1]=4'b0001 and pop_o=4'b0001 in the same cycle; served_q stays 0.
- P0 head 4'b1110, out_ready_i=4'b1010 → cycle 1: grants on outputs 1 and 3, no pop. Then set ready=4'b1111 → cycle 2: grant on output 2 only, pop_o[0]=1.
- P1, P2, P3 all hold target 4'b0001 for 6 cycles, always ready → grant_o[0] sequence 0010, 0100, 1000, 0010, 0100, 1000.
- P2 head 4'b0100 (self only) → no grant, pop_o[2]=1 and drop_o[2]=1 same cycle.
- P0 head 4'b1111 with port_en_i=4'b0111 → grants on outputs 1 and 2 only, pop_o[0]=1, drop_o[0]=0.
- P0 head 4'b0110 with out_ready_i[2]=0; after the output-1 grant, assert rst for 2 cycles → outputs all 0 during reset. After release, output 1 is granted again (served_q cleared) and rr_q is back at 0.
